// File: rtl/sequence_generator_101001_errinj_pkg.sv
// Shared constants for the 101001 generator and its tolerant detector:
// frame shape, FSM encoding and the bit-error tolerance limit.
package sequence_generator_101001_errinj_pkg;

    localparam int               WIDTH        = 6;
    localparam logic [WIDTH-1:0] PATTERN      = 6'b101001;
    localparam int               REPEAT_W     = 4;
    localparam logic [2:0]       TOL_LIMIT    = 3'd2;
    localparam logic [2:0]       LAST_BIT_IDX = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } gen_state_t;

    // A detector that tolerates TOL_LIMIT flipped bits is expected to fire.
    function automatic logic within_tolerance(input logic [2:0] err_count);
        return err_count <= TOL_LIMIT;
    endfunction

endpackage

// File: rtl/sequence_generator_101001_errinj_popcount_6in.sv
// Combinational population count of a 6-bit vector (result 0..6).
module popcount_6in (
    input  logic [5:0] i_bits,
    output logic [2:0] o_count
);

    always_comb begin
        // NOTE: combinational logic uses blocking assignments and gives every output a value first, so no latch is inferred.
        o_count = '0;
        for (int i = 0; i < 6; i++) begin
            o_count = o_count + {2'b00, i_bits[i]};
        end
    end

endmodule

// File: rtl/sequence_generator_101001_errinj.sv
// Serial 101001 frame generator with per-bit error injection and burst repeat;
// reports how many bits were flipped and whether a tolerant detector should still match.
module sequence_generator_101001_errinj
    import sequence_generator_101001_errinj_pkg::*;
#(
    parameter int                                                    WIDTH    = sequence_generator_101001_errinj_pkg::WIDTH,
    parameter logic [sequence_generator_101001_errinj_pkg::WIDTH-1:0] PATTERN = sequence_generator_101001_errinj_pkg::PATTERN,
    parameter int                                                    REPEAT_W = sequence_generator_101001_errinj_pkg::REPEAT_W
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_start,
    input  logic [WIDTH-1:0]    i_err_mask,
    input  logic [REPEAT_W-1:0] i_repeat,
    output logic                o_data,
    output logic                o_valid,
    output logic                o_busy,
    output logic                o_done,
    output logic [2:0]          o_err_count,
    output logic                o_tol_ok
);

    gen_state_t          state_q, state_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [REPEAT_W-1:0] frames_left_q, frames_left_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic                data_d, valid_d, busy_d, done_d, tol_ok_d;
    logic [2:0]          err_count_d;
    logic [2:0]          mask_popcount;

    popcount_6in u_popcount (
        .i_bits  (i_err_mask),
        .o_count (mask_popcount)
    );

    // Frame bit at position idx, counted from the MSB, after error injection.
    function automatic logic frame_bit(input logic [WIDTH-1:0] mask, input logic [2:0] idx);
        logic [WIDTH-1:0] frame;
        frame = (PATTERN ^ mask) << idx;
        return frame[WIDTH-1];
    endfunction

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        frames_left_d = frames_left_q;
        bit_idx_d     = bit_idx_q;
        err_count_d   = o_err_count;
        tol_ok_d      = o_tol_ok;
        data_d        = 1'b0;
        valid_d       = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d       = ST_SEND;
                    mask_d        = i_err_mask;
                    frames_left_d = i_repeat;
                    bit_idx_d     = 3'd0;
                    err_count_d   = mask_popcount;
                    tol_ok_d      = within_tolerance(mask_popcount);
                    data_d        = frame_bit(i_err_mask, 3'd0);
                    valid_d       = 1'b1;
                    busy_d        = 1'b1;
                end
            end

            ST_SEND: begin
                busy_d = 1'b1;
                if (bit_idx_q == LAST_BIT_IDX) begin
                    if (frames_left_q == '0) begin
                        state_d   = ST_DONE;
                        bit_idx_d = 3'd0;
                        done_d    = 1'b1;
                    end else begin
                        // Next frame starts on the very next cycle, no gap.
                        frames_left_d = frames_left_q - 1'b1;
                        bit_idx_d     = 3'd0;
                        data_d        = frame_bit(mask_q, 3'd0);
                        valid_d       = 1'b1;
                    end
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    data_d    = frame_bit(mask_q, bit_idx_q + 3'd1);
                    valid_d   = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and clears every register, including the latched mask.
        if (!i_resetn) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            frames_left_q <= '0;
            bit_idx_q     <= '0;
            o_data        <= 1'b0;
            o_valid       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err_count   <= '0;
            o_tol_ok      <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            frames_left_q <= frames_left_d;
            bit_idx_q     <= bit_idx_d;
            o_data        <= data_d;
            o_valid       <= valid_d;
            o_busy        <= busy_d;
            o_done        <= done_d;
            o_err_count   <= err_count_d;
            o_tol_ok      <= tol_ok_d;
        end
    end

endmodule

// File: tb/tb_sequence_generator_101001_errinj.sv
// Directed bench for the 101001 error-injecting generator: a queue-based
// per-cycle model plus literal expectations for each burst.
module tb_sequence_generator_101001_errinj;

    logic       i_clk = 1'b0;
    logic       i_resetn;
    logic       i_start;
    logic [5:0] i_err_mask;
    logic [3:0] i_repeat;
    logic       o_data, o_valid, o_busy, o_done, o_tol_ok;
    logic [2:0] o_err_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    sequence_generator_101001_errinj dut (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .i_start     (i_start),
        .i_err_mask  (i_err_mask),
        .i_repeat    (i_repeat),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err_count (o_err_count),
        .o_tol_ok    (o_tol_ok)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural model: a queue of expected output cycles
    typedef struct packed {
        logic       data;
        logic       valid;
        logic       busy;
        logic       done;
        logic [2:0] err_count;
        logic       tol_ok;
    } obs_t;

    obs_t       exp_cur = '0;
    obs_t       exp_q[$];
    logic       model_live = 1'b0;
    logic [2:0] model_err = '0;
    logic       model_tol = 1'b0;
    logic [5:0] pattern = 6'b101001;

    always @(posedge i_clk) begin
        if (i_resetn === 1'b0) begin
            exp_q.delete();
            exp_cur    = '0;
            model_err  = '0;
            model_tol  = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (!exp_cur.busy && i_start) begin
                obs_t e;
                model_err = 3'($countones(i_err_mask));
                model_tol = ($countones(i_err_mask) <= 2);
                for (int f = 0; f <= int'(i_repeat); f++) begin
                    for (int b = 0; b < 6; b++) begin
                        e.data      = pattern[5-b] ^ i_err_mask[5-b];
                        e.valid     = 1'b1;
                        e.busy      = 1'b1;
                        e.done      = 1'b0;
                        e.err_count = model_err;
                        e.tol_ok    = model_tol;
                        exp_q.push_back(e);
                    end
                end
                e.data      = 1'b0;
                e.valid     = 1'b0;
                e.busy      = 1'b1;
                e.done      = 1'b1;
                e.err_count = model_err;
                e.tol_ok    = model_tol;
                exp_q.push_back(e);
            end
            if (exp_q.size() > 0) begin
                exp_cur = exp_q.pop_front();
            end else begin
                exp_cur           = '0;
                exp_cur.err_count = model_err;
                exp_cur.tol_ok    = model_tol;
            end
        end
    end

    always @(negedge i_clk) begin
        if (model_live) begin
            check($sformatf("cycle@%0t", $time),
                  96'({o_data, o_valid, o_busy, o_done, o_err_count, o_tol_ok}),
                  96'(exp_cur));
        end
    end

    // ---------------- directed stimulus
    function automatic logic detector_fires(input logic [5:0] frame);
        return $countones(frame ^ 6'b101001) <= 2;
    endfunction

    // Called at a negedge while idle; returns at the negedge of the first idle cycle after the burst.
    task automatic run_burst(input logic [5:0] mask, input logic [3:0] rpt, input bit pulse8,
                             output logic [95:0] bits, output int nbits, output int done_cyc,
                             output int done_cnt, output int busy_cyc,
                             output logic [2:0] err, output logic tol);
        bits = '0; nbits = 0; done_cyc = 0; done_cnt = 0; busy_cyc = 0; err = '0; tol = 1'b0;
        i_err_mask = mask;
        i_repeat   = rpt;
        i_start    = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge i_clk);
            i_start = pulse8 && (c == 8);
            if (o_valid) begin
                bits = {bits[94:0], o_data};
                nbits++;
            end
            if (o_busy) busy_cyc++;
            if (o_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c > 1 && !o_busy) begin
                err = o_err_count;
                tol = o_tol_ok;
                return;
            end
        end
        check("burst_end_timeout", 96'(o_busy), 96'(0));
    endtask

    logic [95:0] bits;
    int          nbits, done_cyc, done_cnt, busy_cyc;
    logic [2:0]  err;
    logic        tol;

    initial begin
        i_resetn   = 1'b0;
        i_start    = 1'b0;
        i_err_mask = '0;
        i_repeat   = '0;
        repeat (3) @(negedge i_clk);
        check("reset_state", 96'({o_data, o_valid, o_busy, o_done, o_err_count, o_tol_ok}), 96'(0));
        i_resetn = 1'b1;
        @(negedge i_clk);

        // Clean single frame.
        run_burst(6'b000000, 4'd0, 1'b0, bits, nbits, done_cyc, done_cnt, busy_cyc, err, tol);
        check("s1_bits",     bits[5:0], 96'(6'b101001));
        check("s1_nbits",    96'(nbits), 96'(6));
        check("s1_done_cyc", 96'(done_cyc), 96'(7));
        check("s1_done_cnt", 96'(done_cnt), 96'(1));
        check("s1_busy_cyc", 96'(busy_cyc), 96'(7));
        check("s1_err",      96'(err), 96'(0));
        check("s1_tol",      96'(tol), 96'(1));

        // Two flipped bits: still within detector tolerance.
        run_burst(6'b100001, 4'd0, 1'b0, bits, nbits, done_cyc, done_cnt, busy_cyc, err, tol);
        check("s2_bits",   bits[5:0], 96'(6'b001000));
        check("s2_err",    96'(err), 96'(2));
        check("s2_tol",    96'(tol), 96'(1));
        check("s2_detect", 96'(detector_fires(bits[5:0])), 96'(1));

        // Three flipped bits: beyond tolerance.
        run_burst(6'b000111, 4'd0, 1'b0, bits, nbits, done_cyc, done_cnt, busy_cyc, err, tol);
        check("s3_bits",   bits[5:0], 96'(6'b101110));
        check("s3_err",    96'(err), 96'(3));
        check("s3_tol",    96'(tol), 96'(0));
        check("s3_detect", 96'(detector_fires(bits[5:0])), 96'(0));

        // Three back-to-back frames with a start pulse mid-burst that must be ignored.
        run_burst(6'b000000, 4'd2, 1'b1, bits, nbits, done_cyc, done_cnt, busy_cyc, err, tol);
        check("s4_nbits",    96'(nbits), 96'(18));
        check("s4_bits",     bits[17:0], 96'({3{6'b101001}}));
        check("s4_done_cyc", 96'(done_cyc), 96'(19));
        check("s4_done_cnt", 96'(done_cnt), 96'(1));
        @(negedge i_clk);
        check("s4_no_restart", 96'(o_busy), 96'(0));

        // Reset while bit_idx=3 aborts the burst with no done pulse.
        done_cnt   = 0;
        i_err_mask = 6'b000000;
        i_repeat   = 4'd0;
        i_start    = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_done) done_cnt++;
        end
        i_resetn = 1'b0;
        @(negedge i_clk);
        check("s5_abort", 96'({o_valid, o_busy, o_done}), 96'(0));
        i_resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_done) done_cnt++;
        end
        check("s5_no_done", 96'(done_cnt), 96'(0));

        // Reset wins over a simultaneous start.
        i_resetn = 1'b0;
        i_start  = 1'b1;
        @(negedge i_clk);
        check("s5_reset_priority", 96'({o_valid, o_busy}), 96'(0));
        i_resetn = 1'b1;
        i_start  = 1'b0;
        @(negedge i_clk);

        run_burst(6'b000000, 4'd0, 1'b0, bits, nbits, done_cyc, done_cnt, busy_cyc, err, tol);
        check("s5_clean_bits", bits[5:0], 96'(6'b101001));
        check("s5_clean_done", 96'(done_cyc), 96'(7));

        // Longest burst, all bits inverted.
        run_burst(6'b111111, 4'd15, 1'b0, bits, nbits, done_cyc, done_cnt, busy_cyc, err, tol);
        check("s6_nbits",    96'(nbits), 96'(96));
        check("s6_bits",     bits, {16{6'b010110}});
        check("s6_err",      96'(err), 96'(6));
        check("s6_tol",      96'(tol), 96'(0));
        check("s6_busy_cyc", 96'(busy_cyc), 96'(97));
        check("s6_done_cyc", 96'(done_cyc), 96'(97));

        repeat (2) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
